// File: rtl/mem_wb_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_wb_stage_pkg
//  Description : Shared definitions for the MEM/WB stage: LSU opcodes, the
//                load-hold FSM state type and the WB control register struct.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_wb_stage_pkg;

    // LSU opcodes; bit 3 selects zero-extension for sub-word loads.
    localparam logic [3:0] LD_B  = 4'b0000;
    localparam logic [3:0] LD_H  = 4'b0001;
    localparam logic [3:0] LD_W  = 4'b0010;
    localparam logic [3:0] LD_BU = 4'b1000;
    localparam logic [3:0] LD_HU = 4'b1001;
    localparam logic [3:0] ST_B  = 4'b0100;
    localparam logic [3:0] ST_H  = 4'b0101;
    localparam logic [3:0] ST_W  = 4'b0110;

    // IDLE: load data comes straight from the SRAM port.
    // HOLD: the SRAM word was captured while stalled and is replayed.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } hold_state_e;

    // Width-independent part of the WB pipeline register.
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        rw_en;
        logic        ram_rd_en;
        logic [3:0]  lsu_op;
        logic        csr_wen;
    } wb_ctrl_t;

endpackage
`default_nettype wire

// File: rtl/mem_wb_stage_load_align.sv
`default_nettype none
// ============================================================================
//  Module      : load_align
//  Description : Combinational load aligner. Selects the byte/half/word at the
//                given offset of the raw SRAM word and sign/zero-extends it.
//  Ports       : raw_i      raw SRAM word
//                lsu_op_i   LSU opcode
//                off_i      low address bits
//                data_o     aligned, extended load data (0 when misaligned)
//                misalign_o access is misaligned for its size
//  Revision    : 1.0  initial release
// ============================================================================
module load_align
    import mem_wb_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] raw_i,
    input  logic [3:0]        lsu_op_i,
    input  logic [1:0]        off_i,
    output logic [DATA_W-1:0] data_o,
    output logic              misalign_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        half_ok;

    always_comb begin
        byte_sel = raw_i[7:0];
        case (off_i)
            2'b00:   byte_sel = raw_i[7:0];
            2'b01:   byte_sel = raw_i[15:8];
            2'b10:   byte_sel = raw_i[23:16];
            default: byte_sel = raw_i[31:24];
        endcase

        half_sel = 16'h0000;
        half_ok  = 1'b1;
        case (off_i)
            2'b00:   half_sel = raw_i[15:0];
            2'b01:   half_sel = raw_i[23:8];
            2'b10:   half_sel = raw_i[31:16];
            default: half_ok  = 1'b0;
        endcase

        data_o     = '0;
        misalign_o = 1'b0;
        case (lsu_op_i)
            LD_B:  data_o = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
            LD_BU: data_o = {{(DATA_W-8){1'b0}}, byte_sel};
            LD_H: begin
                if (half_ok) data_o = {{(DATA_W-16){half_sel[15]}}, half_sel};
                else         misalign_o = 1'b1;
            end
            LD_HU: begin
                if (half_ok) data_o = {{(DATA_W-16){1'b0}}, half_sel};
                else         misalign_o = 1'b1;
            end
            LD_W: begin
                if (off_i == 2'b00) data_o = raw_i;
                else                misalign_o = 1'b1;
            end
            default: data_o = raw_i;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_wb_stage
//  Description : MEM/WB pipeline register and writeback. Completes loads from
//                the one-cycle-latency SRAM, holding the returned word across
//                stalls, and drives the RF/CSR write ports and WB trace.
//  Ports       : clk, rst_n (sync, active low), stall, flush
//                m_*           memory-stage instruction fields
//                sram_rd_data  SRAM word, valid the cycle after the request
//                rf_*/csr_*    write ports, gated to fire once per instruction
//                wb_valid/pc/inst, ld_misalign  WB status
//  Options     : MEM_WB_DIFFTEST_EN adds commit_valid/commit_ld_vaddr/
//                commit_wdata trace outputs (one-cycle-delayed retire info).
//  Revision    : 1.0  initial release
// ============================================================================
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int RF_ADDR_W  = 5,
    parameter int CSR_ADDR_W = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  m_valid,
    input  logic [31:0]           m_pc,
    input  logic [31:0]           m_inst,
    input  logic                  m_rw_en,
    input  logic [RF_ADDR_W-1:0]  m_rw_addr,
    input  logic [DATA_W-1:0]     m_rw_data,
    input  logic                  m_ram_rd_en,
    input  logic [3:0]            m_lsu_op,
    input  logic                  m_csr_wen,
    input  logic [CSR_ADDR_W-1:0] m_csr_waddr,
    input  logic [DATA_W-1:0]     m_csr_wdata,
    input  logic [DATA_W-1:0]     sram_rd_data,
    output logic                  rf_we,
    output logic [RF_ADDR_W-1:0]  rf_waddr,
    output logic [DATA_W-1:0]     rf_wdata,
    output logic                  csr_we,
    output logic [CSR_ADDR_W-1:0] csr_waddr,
    output logic [DATA_W-1:0]     csr_wdata,
    output logic                  wb_valid,
    output logic [31:0]           wb_pc,
    output logic [31:0]           wb_inst,
    output logic                  ld_misalign
`ifdef MEM_WB_DIFFTEST_EN
    ,
    output logic                  commit_valid,
    output logic [31:0]           commit_ld_vaddr,
    output logic [31:0]           commit_wdata
`endif
);

    wb_ctrl_t              ctrl_q;
    logic [RF_ADDR_W-1:0]  rw_addr_q;
    logic [DATA_W-1:0]     rw_data_q;
    logic [CSR_ADDR_W-1:0] csr_waddr_q;
    logic [DATA_W-1:0]     csr_wdata_q;

    hold_state_e           state_q, state_d;
    logic [DATA_W-1:0]     hold_q, hold_d;

    logic [DATA_W-1:0]     raw_word;
    logic [DATA_W-1:0]     ld_data;
    logic                  ld_mis;

    // ---------------- WB pipeline register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_q      <= '0;
            rw_addr_q   <= '0;
            rw_data_q   <= '0;
            csr_waddr_q <= '0;
            csr_wdata_q <= '0;
        end else if (!stall) begin
            if (flush) begin
                ctrl_q.valid <= 1'b0;
            end else begin
                ctrl_q.valid     <= m_valid;
                ctrl_q.pc        <= m_pc;
                ctrl_q.inst      <= m_inst;
                ctrl_q.rw_en     <= m_rw_en;
                ctrl_q.ram_rd_en <= m_ram_rd_en;
                ctrl_q.lsu_op    <= m_lsu_op;
                ctrl_q.csr_wen   <= m_csr_wen;
                rw_addr_q        <= m_rw_addr;
                rw_data_q        <= m_rw_data;
                csr_waddr_q      <= m_csr_waddr;
                csr_wdata_q      <= m_csr_wdata;
            end
        end
    end

    // ---------------- Load-hold FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    // The SRAM word is only on its port during the first WB cycle; if that
    // cycle is stalled, capture it so the eventual write uses the right word.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (stall && ctrl_q.valid && ctrl_q.ram_rd_en) begin
                    state_d = HOLD;
                    hold_d  = sram_rd_data;
                end
            end
            HOLD: begin
                if (!stall) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign raw_word = (state_q == HOLD) ? hold_q : sram_rd_data;

    load_align #(
        .DATA_W (DATA_W)
    ) u_load_align (
        .raw_i      (raw_word),
        .lsu_op_i   (ctrl_q.lsu_op),
        .off_i      (rw_data_q[1:0]),
        .data_o     (ld_data),
        .misalign_o (ld_mis)
    );

    // ---------------- Writeback outputs ----------------
    assign ld_misalign = ctrl_q.valid & ctrl_q.ram_rd_en & ld_mis;

    // Gating on ~stall makes each write fire only in the first unstalled cycle.
    assign rf_we    = ctrl_q.valid & ctrl_q.rw_en & (rw_addr_q != '0)
                    & ~ld_misalign & ~stall;
    assign rf_waddr = rw_addr_q;
    assign rf_wdata = ld_misalign      ? '0      :
                      ctrl_q.ram_rd_en ? ld_data : rw_data_q;

    assign csr_we    = ctrl_q.valid & ctrl_q.csr_wen & ~stall;
    assign csr_waddr = csr_waddr_q;
    assign csr_wdata = csr_wdata_q;

    assign wb_valid = ctrl_q.valid;
    assign wb_pc    = ctrl_q.pc;
    assign wb_inst  = ctrl_q.inst;

`ifdef MEM_WB_DIFFTEST_EN
    logic        commit_valid_q;
    logic [31:0] commit_ld_vaddr_q;
    logic [31:0] commit_wdata_q;

    // An instruction retires in its single unstalled WB cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            commit_valid_q    <= 1'b0;
            commit_ld_vaddr_q <= '0;
            commit_wdata_q    <= '0;
        end else begin
            commit_valid_q    <= ctrl_q.valid & ~stall;
            commit_ld_vaddr_q <= ctrl_q.ram_rd_en ? rw_data_q[31:0] : 32'h0;
            commit_wdata_q    <= rf_we  ? rf_wdata[31:0]  :
                                 csr_we ? csr_wdata[31:0] : 32'h0;
        end
    end

    assign commit_valid    = commit_valid_q;
    assign commit_ld_vaddr = commit_ld_vaddr_q;
    assign commit_wdata    = commit_wdata_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_wb_stage
//  Description : Directed self-checking bench for mem_wb_stage.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_wb_stage;
    import mem_wb_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, stall, flush;
    logic        m_valid, m_rw_en, m_ram_rd_en, m_csr_wen;
    logic [31:0] m_pc, m_inst, m_rw_data, m_csr_wdata, sram_rd_data;
    logic [4:0]  m_rw_addr;
    logic [3:0]  m_lsu_op;
    logic [13:0] m_csr_waddr;
    logic        rf_we, csr_we, wb_valid, ld_misalign;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, csr_wdata, wb_pc, wb_inst;
    logic [13:0] csr_waddr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_wb_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .m_valid(m_valid), .m_pc(m_pc), .m_inst(m_inst),
        .m_rw_en(m_rw_en), .m_rw_addr(m_rw_addr), .m_rw_data(m_rw_data),
        .m_ram_rd_en(m_ram_rd_en), .m_lsu_op(m_lsu_op),
        .m_csr_wen(m_csr_wen), .m_csr_waddr(m_csr_waddr), .m_csr_wdata(m_csr_wdata),
        .sram_rd_data(sram_rd_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
        .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_inst(wb_inst),
        .ld_misalign(ld_misalign)
    );

    // Advance one clock; inputs change 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mem_clear();
        m_valid = 0; m_rw_en = 0; m_rw_addr = 0; m_rw_data = 0;
        m_ram_rd_en = 0; m_lsu_op = 0; m_csr_wen = 0; m_csr_waddr = 0;
        m_csr_wdata = 0; m_pc = 0; m_inst = 0;
    endtask

    task automatic mem_load(input logic [31:0] addr, input logic [3:0] op,
                            input logic [4:0] rd);
        mem_clear();
        m_valid = 1; m_pc = 32'h8000_0000 + addr; m_inst = 32'h0000_0003;
        m_rw_en = 1; m_rw_addr = rd; m_rw_data = addr; m_ram_rd_en = 1;
        m_lsu_op = op;
    endtask

    task automatic test_reset();
        rst_n = 0; stall = 0; flush = 0; sram_rd_data = 32'hFFFF_FFFF;
        mem_load(32'h1000, LD_W, 5'd1);
        step(); step();
        checks++;
        if ({wb_valid, rf_we, csr_we, ld_misalign} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: got %b expected 0000",
                               {wb_valid, rf_we, csr_we, ld_misalign});
        end
        checks++;
        if ({wb_pc, wb_inst, rf_wdata, csr_wdata} !== 128'h0) begin
            errors++; $display("FAIL reset_data: got pc=%h inst=%h rf=%h csr=%h expected 0",
                               wb_pc, wb_inst, rf_wdata, csr_wdata);
        end
        mem_clear();
        rst_n = 1;
        step();
    endtask

    // Issue one load, then supply the SRAM word in its WB cycle and check.
    task automatic run_load(input string nm, input logic [31:0] addr,
                            input logic [3:0] op, input logic [4:0] rd,
                            input logic [31:0] word, input logic exp_we,
                            input logic exp_mis, input logic [31:0] exp_data);
        mem_load(addr, op, rd);
        step();
        mem_clear();
        sram_rd_data = word;
        #1;
        checks++;
        if ({rf_we, ld_misalign} !== {exp_we, exp_mis} || rf_wdata !== exp_data) begin
            errors++;
            $display("FAIL %s: got we=%b mis=%b data=%h expected we=%b mis=%b data=%h",
                     nm, rf_we, ld_misalign, rf_wdata, exp_we, exp_mis, exp_data);
        end
        if (exp_we) begin
            checks++;
            if (rf_waddr !== rd) begin
                errors++; $display("FAIL %s_addr: got %0d expected %0d", nm, rf_waddr, rd);
            end
        end
        step();
    endtask

    task automatic test_load_align();
        run_load("ld_b_off3",   32'h1003, LD_B,  5'd3, 32'h8011_2233, 1, 0, 32'hFFFF_FF80);
        run_load("ld_hu_off1",  32'h2001, LD_HU, 5'd4, 32'hAABB_CCDD, 1, 0, 32'h0000_BBCC);
        run_load("ld_h_off2",   32'h2002, LD_H,  5'd4, 32'h8001_1234, 1, 0, 32'hFFFF_8001);
        run_load("ld_h_off3",   32'h2003, LD_H,  5'd4, 32'hAABB_CCDD, 0, 1, 32'h0000_0000);
        run_load("ld_bu_off0",  32'h2000, LD_BU, 5'd6, 32'h1234_56F0, 1, 0, 32'h0000_00F0);
        run_load("ld_b_off1",   32'h2001, LD_B,  5'd6, 32'h1234_7F00, 1, 0, 32'h0000_007F);
        run_load("ld_w_off0",   32'h2000, LD_W,  5'd8, 32'hCAFE_F00D, 1, 0, 32'hCAFE_F00D);
        run_load("ld_w_off2",   32'h2002, LD_W,  5'd8, 32'hCAFE_F00D, 0, 1, 32'h0000_0000);
        run_load("ld_w_r0",     32'h2000, LD_W,  5'd0, 32'h1111_2222, 0, 0, 32'h1111_2222);
    endtask

    task automatic test_stall_hold();
        int pulses;
        mem_load(32'h3000, LD_W, 5'd7);
        step();
        mem_clear();
        sram_rd_data = 32'h1234_5678;
        stall = 1;
        #1;
        checks++;
        if (rf_we !== 1'b0) begin
            errors++; $display("FAIL hold_first_stall_we: got %b expected 0", rf_we);
        end
        step();
        sram_rd_data = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (dut.state_q !== HOLD) begin
            errors++; $display("FAIL hold_state: got %0d expected %0d", dut.state_q, HOLD);
        end
        pulses = 0;
        for (int i = 0; i < 2; i++) begin
            step();
            if (rf_we) pulses++;
        end
        stall = 0;
        #1;
        checks++;
        if (rf_we !== 1'b1 || rf_wdata !== 32'h1234_5678 || rf_waddr !== 5'd7) begin
            errors++; $display("FAIL hold_release: got we=%b data=%h rd=%0d expected we=1 data=12345678 rd=7",
                               rf_we, rf_wdata, rf_waddr);
        end
        if (rf_we) pulses++;
        step();
        if (rf_we) pulses++;
        checks++;
        if (pulses !== 1) begin
            errors++; $display("FAIL hold_pulses: got %0d expected 1", pulses);
        end
        checks++;
        if (dut.state_q !== IDLE || wb_valid !== 1'b0) begin
            errors++; $display("FAIL hold_exit: got state=%0d valid=%b expected state=0 valid=0",
                               dut.state_q, wb_valid);
        end
    endtask

    task automatic test_flush_r0();
        mem_clear();
        m_valid = 1; m_rw_en = 1; m_rw_addr = 5'd5; m_rw_data = 32'h55;
        flush = 1;
        step();
        flush = 0;
        mem_clear();
        checks++;
        if (wb_valid !== 1'b0 || rf_we !== 1'b0) begin
            errors++; $display("FAIL flush_kill: got valid=%b we=%b expected 0 0", wb_valid, rf_we);
        end
        m_valid = 1; m_rw_en = 1; m_rw_addr = 5'd5; m_rw_data = 32'h55;
        m_pc = 32'h0000_0100; m_inst = 32'h0050_0293;
        step();
        mem_clear();
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h55 ||
            wb_pc !== 32'h100 || wb_inst !== 32'h0050_0293) begin
            errors++; $display("FAIL alu_write: got we=%b rd=%0d data=%h pc=%h inst=%h expected 1 5 55 100 00500293",
                               rf_we, rf_waddr, rf_wdata, wb_pc, wb_inst);
        end
        m_valid = 1; m_rw_en = 1; m_rw_addr = 5'd0; m_rw_data = 32'h55;
        step();
        mem_clear();
        checks++;
        if (rf_we !== 1'b0 || wb_valid !== 1'b1) begin
            errors++; $display("FAIL alu_r0: got we=%b valid=%b expected we=0 valid=1", rf_we, wb_valid);
        end
        step();
    endtask

    task automatic test_csr_stall();
        int pulses;
        mem_clear();
        m_valid = 1; m_csr_wen = 1; m_csr_waddr = 14'h180; m_csr_wdata = 32'h7;
        step();
        mem_clear();
        stall = 1;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (csr_we) pulses++;
            step();
        end
        checks++;
        if (pulses !== 0) begin
            errors++; $display("FAIL csr_stalled: got %0d pulses expected 0", pulses);
        end
        stall = 0;
        #1;
        checks++;
        if (csr_we !== 1'b1 || csr_waddr !== 14'h180 || csr_wdata !== 32'h7) begin
            errors++; $display("FAIL csr_release: got we=%b addr=%h data=%h expected 1 180 7",
                               csr_we, csr_waddr, csr_wdata);
        end
        step();
        checks++;
        if (csr_we !== 1'b0) begin
            errors++; $display("FAIL csr_once: got %b expected 0", csr_we);
        end
    endtask

    task automatic test_reset_in_hold();
        mem_load(32'h4000, LD_W, 5'd9);
        step();
        mem_clear();
        sram_rd_data = 32'hA5A5_A5A5;
        stall = 1;
        step();
        checks++;
        if (dut.state_q !== HOLD) begin
            errors++; $display("FAIL rsthold_pre: got state=%0d expected %0d", dut.state_q, HOLD);
        end
        rst_n = 0;
        step();
        rst_n = 1;
        #1;
        checks++;
        if ({wb_valid, rf_we, csr_we, ld_misalign} !== 4'b0000 ||
            wb_pc !== 32'h0 || rf_wdata !== 32'h0 || dut.state_q !== IDLE) begin
            errors++; $display("FAIL rsthold_clear: got flags=%b pc=%h data=%h state=%0d expected 0000 0 0 0",
                               {wb_valid, rf_we, csr_we, ld_misalign}, wb_pc, rf_wdata, dut.state_q);
        end
        step();
        stall = 0;
        #1;
        checks++;
        if (rf_we !== 1'b0) begin
            errors++; $display("FAIL rsthold_release: got we=%b expected 0", rf_we);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_load_align();
        test_stall_hold();
        test_flush_r0();
        test_csr_stall();
        test_reset_in_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Pipeline register plus writeback logic directly downstream of the memory-access stage.
- Captures memory-stage results each cycle and completes loads: the synchronous SRAM returns read data one cycle after the request, and this block aligns and sign/zero-extends it.
- Drives the register-file and CSR write ports and the commit/lsu trace.
- Holds load data across stalls so a stalled load never loses its SRAM word.

Parameters:
- DATA_W, 32, datapath and register width.
- RF_ADDR_W, 5, register-file address width.
- CSR_ADDR_W, 14, CSR address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- stall  in  1  hold the WB register (same stall that freezes the memory stage)
- flush  in  1  kill the instruction entering WB
- m_valid  in  1  memory-stage instruction valid
- m_pc  in  32  memory-stage PC
- m_inst  in  32  memory-stage instruction
- m_rw_en  in  1  register write enable
- m_rw_addr  in  RF_ADDR_W  destination register
- m_rw_data  in  DATA_W  ALU result / effective address
- m_ram_rd_en  in  1  instruction is a load
- m_lsu_op  in  4  LSU opcode
- m_csr_wen  in  1  CSR write enable
- m_csr_waddr  in  CSR_ADDR_W  CSR address
- m_csr_wdata  in  DATA_W  CSR write data
- sram_rd_data  in  DATA_W  SRAM word, valid the cycle after the request
- rf_we  out  1  register-file write enable
- rf_waddr  out  RF_ADDR_W  register-file write address
- rf_wdata  out  DATA_W  register-file write data
- csr_we  out  1  CSR write enable
- csr_waddr  out  CSR_ADDR_W  CSR write address
- csr_wdata  out  DATA_W  CSR write data
- wb_valid  out  1  valid instruction in WB
- wb_pc  out  32  WB PC
- wb_inst  out  32  WB instruction
- ld_misalign  out  1  misaligned load detected in WB

Behaviour:
- Reset (rst_n=0 at a clk edge): all WB registers clear; wb_valid=0, rf_we=0, csr_we=0, ld_misalign=0, pc/inst/data outputs=0; hold FSM returns to IDLE. Reset overrides stall and flush.
- Register update priority: reset > stall > flush > load.
  - stall=1: all WB registers keep their values.
  - stall=0, flush=1: wb_valid<=0; other fields are don't-care.
  - Otherwise: all m_* fields are captured; wb_valid<=m_valid.
- Write gating: rf_we = wb_valid & wb_rw_en & (wb_rw_addr!=0) & ~ld_misalign & ~stall. csr_we = wb_valid & wb_csr_wen & ~stall. Writes therefore fire exactly once, in the first non-stalled cycle.
- Non-load data: rf_wdata = registered m_rw_data.
- Load data source: the raw word is sram_rd_data in state IDLE and hold_q in state HOLD.
- Load alignment, using off = wb_rw_data[1:0]:
  - ld.b (0000) / ld.bu (1000): byte at off; sign-extend / zero-extend.
  - ld.h (0001) / ld.hu (1001): off 00 -> [15:0]; 01 -> [23:8]; 10 -> [31:16]; 11 -> misaligned.
  - ld.w (0010): off 00 -> whole word; any other offset -> misaligned.
- ld_misalign = wb_valid & wb_ram_rd_en & misaligned; rf write suppressed; rf_wdata=0.
- Hold FSM (IDLE, HOLD):
  - IDLE -> HOLD when stall & wb_valid & wb_ram_rd_en; hold_q<=sram_rd_data in that same cycle.
  - HOLD -> IDLE when stall=0. The WB register advances in that cycle; the held data is used for the current write.
  - flush while in HOLD: no effect, since flush only acts when stall=0.
  - Reset in HOLD -> IDLE.
- The load write completes in the first non-stalled WB cycle using the held word. Latency: memory-stage request cycle N -> RF write at cycle N+1 if no stall.
- Loads to r0: alignment still computed, rf_we=0.

Optional Feature:
- Macro: MEM_WB_DIFFTEST_EN.
- Defined: adds output ports commit_valid (1), commit_ld_vaddr (32), commit_wdata (32), registered one cycle after an rf/csr write or valid-instruction retire, for the difftest trace; commit_valid pulses once per retired instruction, even across stalls.
- Undefined: ports and registers absent; no other behaviour changes.

Decomposition:
- Shared package: LSU opcode constants (LD_B 4'b0000, LD_H 4'b0001, LD_W 4'b0010, LD_BU 4'b1000, LD_HU 4'b1001, ST_B/H/W), a hold-state enum, and a WB pipeline-register struct typedef.
- One sub-module: load_align (combinational: raw word, lsu_op, off -> aligned data, misalign).

Test Plan:
- ld.b, addr 0x1003, sram 0x80112233, no stall -> next cycle rf_we=1, rf_wdata=0xFFFFFF80.
- ld.hu, off 01, sram 0xAABBCCDD -> rf_wdata=0x0000BBCC; ld.h off 11 -> ld_misalign=1, rf_we=0.
- ld.w, stall held 3 cycles while sram_rd_data changes to 0xDEADBEEF -> FSM in HOLD; single write on release with the originally captured word 0x12345678.
- ALU op to r5, data 0x55 with flush=1 on capture -> wb_valid=0, no write; same op with rd=r0 -> rf_we=0.
- CSR write 0x180=0x7 during stall -> csr_we=0 until stall drops, then exactly one pulse.
- Assert rst_n=0 while in HOLD with a valid load -> next cycle all outputs 0, FSM IDLE, no write after release.
